// File: rtl/reg_y_bank.sv
// ============================================================================
// Module   : reg_y_bank
// Purpose  : Y-bus register endpoint holding R3..R10 plus a memory-fetched DR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_y_bank #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus,
  input  logic [7:0] enY,
  input  logic       wr_en,
  input  logic       inc_en,
  input  logic [2:0] inc_sel,
  input  logic       dr_req,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] R3,
  output logic [7:0] R4,
  output logic [7:0] R5,
  output logic [7:0] R6,
  output logic [7:0] R7,
  output logic [7:0] R8,
  output logic [7:0] R9,
  output logic [7:0] R10,
  output logic [7:0] DR,
  output logic       mem_rd,
  output logic       dr_busy,
  output logic       dr_done,
  output logic       dr_timeout,
  output logic       inc_carry,
  output logic       wr_err
);

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [7:0] r_regs [8];
  logic [7:0] w_inc_hit;
  logic       w_onehot;
  logic       w_wr_ok;
  logic       w_inc_ok;

  assign w_onehot = (enY != 8'd0) && ((enY & (enY - 8'd1)) == 8'd0);
  assign w_wr_ok  = wr_en && w_onehot;
  // A write to the increment target takes priority and suppresses the increment.
  assign w_inc_ok = inc_en && !(w_wr_ok && enY[inc_sel]);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      assign w_inc_hit[gi] = w_inc_ok && (inc_sel == 3'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_regs[gi] <= 8'd0;
        end else if (w_wr_ok && enY[gi]) begin
          r_regs[gi] <= bus;
        end else if (w_inc_hit[gi]) begin
          r_regs[gi] <= r_regs[gi] + 8'd1;
        end
      end
    end
  endgenerate

  logic r_inc_carry;
  logic r_wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_carry <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_inc_carry <= w_inc_ok && (r_regs[inc_sel] == 8'hFF);
      if (wr_en && !w_onehot) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // DR fetch handshake
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] r_dr;
  logic [7:0] w_dr_nxt;
  logic       r_dr_done;
  logic       w_done_nxt;
  logic       r_dr_timeout;
  logic       w_timeout_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_dr         <= 8'd0;
      r_dr_done    <= 1'b0;
      r_dr_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dr         <= w_dr_nxt;
      r_dr_done    <= w_done_nxt;
      r_dr_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dr_nxt      = r_dr;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dr_req) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_dr_nxt    = mem_rdata;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_rd     = (r_state == S_WAIT);
  assign dr_busy    = (r_state == S_WAIT);
  assign dr_done    = r_dr_done;
  assign dr_timeout = r_dr_timeout;
  assign DR         = r_dr;
  assign inc_carry  = r_inc_carry;
  assign wr_err     = r_wr_err;

  assign R3  = r_regs[0];
  assign R4  = r_regs[1];
  assign R5  = r_regs[2];
  assign R6  = r_regs[3];
  assign R7  = r_regs[4];
  assign R8  = r_regs[5];
  assign R9  = r_regs[6];
  assign R10 = r_regs[7];

endmodule

`default_nettype wire

// File: tb/tb_reg_y_bank.sv
// ============================================================================
// Module   : tb_reg_y_bank
// Purpose  : Directed self-checking bench for reg_y_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_y_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus;
  logic [7:0] enY;
  logic       wr_en;
  logic       inc_en;
  logic [2:0] inc_sel;
  logic       dr_req;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] R3, R4, R5, R6, R7, R8, R9, R10, DR;
  logic       mem_rd, dr_busy, dr_done, dr_timeout, inc_carry, wr_err;

  int n_checks;
  int n_fail;
  int n;

  reg_y_bank #(.TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .enY(enY), .wr_en(wr_en),
    .inc_en(inc_en), .inc_sel(inc_sel), .dr_req(dr_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7), .R8(R8), .R9(R9), .R10(R10),
    .DR(DR), .mem_rd(mem_rd), .dr_busy(dr_busy), .dr_done(dr_done),
    .dr_timeout(dr_timeout), .inc_carry(inc_carry), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    wr_en  = 1'b0;
    enY    = 8'd0;
    inc_en = 1'b0;
    dr_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; bus = 8'd0; inc_sel = 3'd0; mem_rdata = 8'd0; mem_ack = 1'b0;
    clear_strobes();
    tick(); tick();
    check("rst_R3", 16'(R3), 16'h00);
    check("rst_R10", 16'(R10), 16'h00);
    check("rst_DR", 16'(DR), 16'h00);
    check("rst_ctl", {10'd0, mem_rd, dr_busy, dr_done, dr_timeout, inc_carry, wr_err}, 16'h0);
    rst_n = 1'b1;
    tick();

    // single write to R5
    wr_en = 1'b1; enY = 8'b0000_0100; bus = 8'hA5;
    tick(); clear_strobes();
    check("wr_R5", 16'(R5), 16'hA5);
    check("wr_R3", 16'(R3), 16'h00);
    check("wr_R6", 16'(R6), 16'h00);
    check("wr_err0", 16'(wr_err), 16'h0);

    // multi-hot write is dropped and flags sticky error
    wr_en = 1'b1; enY = 8'b0001_1000; bus = 8'h77;
    tick(); clear_strobes();
    check("mh_R6", 16'(R6), 16'h00);
    check("mh_R7", 16'(R7), 16'h00);
    check("mh_R5", 16'(R5), 16'hA5);
    check("mh_err", 16'(wr_err), 16'h1);
    tick(); tick();
    check("mh_err_sticky", 16'(wr_err), 16'h1);

    // increment wrap on R10
    wr_en = 1'b1; enY = 8'h80; bus = 8'hFF;
    tick(); clear_strobes();
    check("ld_R10", 16'(R10), 16'hFF);
    inc_en = 1'b1; inc_sel = 3'd7;
    tick(); clear_strobes();
    check("wrap_R10", 16'(R10), 16'h00);
    check("wrap_carry", 16'(inc_carry), 16'h1);
    tick();
    check("carry_pulse", 16'(inc_carry), 16'h0);

    // write beats increment on the same register
    wr_en = 1'b1; enY = 8'h01; bus = 8'h10; inc_en = 1'b1; inc_sel = 3'd0;
    tick(); clear_strobes();
    check("wi_R3", 16'(R3), 16'h10);
    check("wi_carry", 16'(inc_carry), 16'h0);

    // write and increment to different registers
    wr_en = 1'b1; enY = 8'h02; bus = 8'h20; inc_en = 1'b1; inc_sel = 3'd2;
    tick(); clear_strobes();
    check("wd_R4", 16'(R4), 16'h20);
    check("wd_R5", 16'(R5), 16'hA6);

    // DR fetch with ack in 4th WAIT cycle, extra dr_req ignored
    dr_req = 1'b1; mem_rdata = 8'h3C;
    tick();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      dr_req  = (i == 0);
      mem_ack = (i == 3);
      if (mem_rd) n++;
      tick();
    end
    mem_ack = 1'b0; dr_req = 1'b0; mem_rdata = 8'h00;
    check("ack_rd_cycles", 16'(n), 16'd4);
    check("ack_DR", 16'(DR), 16'h3C);
    check("ack_done", 16'(dr_done), 16'h1);
    check("ack_idle", {14'd0, mem_rd, dr_busy}, 16'h0);
    tick();
    check("ack_done_pulse", 16'(dr_done), 16'h0);
    check("ack_no_requeue", 16'(mem_rd), 16'h0);

    // timeout: no ack ever
    dr_req = 1'b1; mem_rdata = 8'h55;
    tick(); dr_req = 1'b0;
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      tick();
    end
    check("to_rd_cycles", 16'(n), 16'd16);
    check("to_pulse", 16'(dr_timeout), 16'h1);
    check("to_no_done", 16'(dr_done), 16'h0);
    check("to_DR_kept", 16'(DR), 16'h3C);
    tick();
    check("to_pulse_end", 16'(dr_timeout), 16'h0);

    // ack on the last counted cycle wins over timeout
    dr_req = 1'b1; mem_rdata = 8'hC3;
    tick(); dr_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("race_rd", 16'(mem_rd), 16'h1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check("race_done", 16'(dr_done), 16'h1);
    check("race_no_to", 16'(dr_timeout), 16'h0);
    check("race_DR", 16'(DR), 16'hC3);
    tick();

    // async reset in 2nd WAIT cycle
    dr_req = 1'b1;
    tick(); dr_req = 1'b0;
    tick();
    check("rst_mid_rd_before", 16'(mem_rd), 16'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rd", 16'(mem_rd), 16'h0);
    check("rst_mid_R5", 16'(R5), 16'h00);
    check("rst_mid_err", 16'(wr_err), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_pulses", {14'd0, dr_done, dr_timeout}, 16'h0);
    check("rst_mid_DR", 16'(DR), 16'h00);

    // minimum latency fetch after reset
    dr_req = 1'b1;
    tick(); dr_req = 1'b0;
    check("min_busy", 16'(dr_busy), 16'h1);
    mem_ack = 1'b1; mem_rdata = 8'h9A;
    tick(); mem_ack = 1'b0;
    check("min_done", 16'(dr_done), 16'h1);
    check("min_DR", 16'(DR), 16'h9A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
